ysyx_23060184_ifu: RTL
======================

# ysyx_23060184_ifu

Instruction fetch unit for the single-issue NPC core. Holds the architectural PC, fetches one instruction per round over a valid/ready instruction-memory read channel, and presents it, pre-split into opcode/funct fields, to the decode/control stage. After decode accepts an instruction, the unit waits for the next PC from the execute/commit path before fetching again.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- XLEN, 32, address and instruction width

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- araddr  out  XLEN  fetch address ({pc[31:2],2'b00})
- arvalid  out  1  fetch request valid
- arready  in  1  memory accepts request
- rdata  in  XLEN  returned instruction word
- rresp  in  2  response code; 2'b00 = OKAY
- rvalid  in  1  response valid
- rready  out  1  IFU accepts response
- inst  out  XLEN  captured instruction
- pc  out  XLEN  PC of `inst`
- opcode  out  `OPCODE_LENGTH  inst[6:0]
- funct3  out  `FUNCT3_LENGTH  inst[14:12]
- funct7  out  `FUNCT7_LENGTH  inst[31:25]
- funct12  out  `FUNCT12_LENGTH  inst[31:20]
- inst_valid  out  1  `inst`/`pc` valid to decode
- inst_ready  in  1  decode accepts instruction
- npc  in  XLEN  next PC from execute/commit
- npc_valid  in  1  `npc` valid (one-cycle pulse)
- fetch_err  out  1  captured instruction had non-OKAY rresp

## Operation
- FSM states: S_FETCH, S_WAIT, S_VALID, S_EXEC.
- S_FETCH: arvalid=1, araddr from pc. arvalid&arready -> S_WAIT. araddr stable while arvalid high.
- S_WAIT: rready=1. rvalid -> latch rdata into inst, fetch_err <= (rresp != 2'b00) -> S_VALID.
- S_VALID: inst_valid=1; inst, pc, fields held stable. inst_valid&inst_ready -> S_EXEC.
- S_EXEC: wait for npc_valid; on it, pc <= npc -> S_FETCH.
- npc_valid outside S_EXEC ignored (no queuing). rvalid outside S_WAIT and arready outside S_FETCH ignored.
- npc low bits: pc stores npc unmodified; araddr forces bits [1:0] to 0.
- fetch_err: inst still forwarded; flag held until next capture in S_WAIT.
- Field outputs combinational slices of the inst register.
- Only one outstanding request; no speculation, no prefetch.

## Timing
- Reset (async assert, sync deassert by upstream synchronizer): state=S_FETCH, pc=RESET_PC, inst=0, fetch_err=0, arvalid=1 (combinationally from state), rready=0, inst_valid=0.
- All outputs are functions of registered state only; no input-to-output combinational path.
- Best case: arready in cycle 0, rvalid in cycle 1 -> inst_valid in cycle 2. inst_ready in cycle 2 -> S_EXEC cycle 3; npc_valid in cycle 3 -> arvalid with new address in cycle 4.
- Back-pressure: arready low holds S_FETCH indefinitely; rvalid low holds S_WAIT; inst_ready low holds S_VALID with all outputs stable.
- Reset mid-round: any state returns to S_FETCH at RESET_PC; the in-flight response is dropped (memory-side reset assumed simultaneous).

## Structure
- Shared `ysyx_23060184_defines.vh`: `OPCODE_LENGTH`, `FUNCT3_LENGTH`, `FUNCT7_LENGTH`, `FUNCT12_LENGTH`, `RESET_PC` default, IFU state encodings, `RESP_OKAY`.
- One sub-module: `ysyx_23060184_pc_reg` (reset-to-RESET_PC, write-enable register), reusable for other PC-carrying stage registers.
- FSM and inst capture inline.

## Test plan
- Reset release, memory arready=1, rvalid one cycle later with rdata=32'h00000413 -> araddr=32'h8000_0000, inst_valid in cycle 2, opcode=7'h13, funct3=0, pc=32'h8000_0000.
- Hold arready low 5 cycles -> arvalid stays 1, araddr stable, no state change; then completes normally.
- inst_ready low 4 cycles in S_VALID -> inst/pc/inst_valid stable; npc_valid pulses during that window ignored; pc unchanged.
- npc=32'h8000_0102 in S_EXEC -> pc=32'h8000_0102, araddr=32'h8000_0100.
- rresp=2'b10 with rdata=32'hDEADBEEF -> inst=32'hDEADBEEF, fetch_err=1; next OKAY fetch clears fetch_err.
- Assert rstn low while in S_WAIT -> immediately state S_FETCH, inst_valid=0, rready=0, pc=RESET_PC.

Source files
------------

// File: rtl/ysyx_23060184_ifu_pkg.sv
// Shared constants for the IFU: field widths, reset PC default, FSM encodings, response codes.
package ysyx_23060184_ifu_pkg;

  localparam int unsigned OPCODE_LENGTH  = 7;
  localparam int unsigned FUNCT3_LENGTH  = 3;
  localparam int unsigned FUNCT7_LENGTH  = 7;
  localparam int unsigned FUNCT12_LENGTH = 12;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // IFU state encodings
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060184_pc_reg.sv
// Write-enabled register that resets to a fixed PC; usable for any PC-carrying stage register.
module ysyx_23060184_pc_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d, val_q;

  // Load new value only when enabled
  always_comb begin
    val_d = we ? d : val_q;
  end

  // State register with async reset to RESET_VAL
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: one fetch round per instruction over a valid/ready memory channel,
// presents the captured word to decode, then waits for the next PC from execute/commit.
module ysyx_23060184_ifu
  import ysyx_23060184_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic [XLEN-1:0]           araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [XLEN-1:0]           rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [XLEN-1:0]           inst,
  output logic [XLEN-1:0]           pc,
  output logic [OPCODE_LENGTH-1:0]  opcode,
  output logic [FUNCT3_LENGTH-1:0]  funct3,
  output logic [FUNCT7_LENGTH-1:0]  funct7,
  output logic [FUNCT12_LENGTH-1:0] funct12,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  input  logic [XLEN-1:0]           npc,
  input  logic                      npc_valid,
  output logic                      fetch_err
);

  logic [1:0]      state_d, state_q;
  logic [XLEN-1:0] inst_d, inst_q;
  logic            fetch_err_d, fetch_err_q;
  logic            pc_we;

  // PC only changes when execute hands over the next PC in S_EXEC
  assign pc_we = (state_q == S_EXEC) && npc_valid;

  ysyx_23060184_pc_reg #(
    .WIDTH    (XLEN),
    .RESET_VAL(XLEN'(RESET_PC))
  ) u_pc_reg (
    .clk (clk),
    .rstn(rstn),
    .we  (pc_we),
    .d   (npc),
    .q   (pc)
  );

  // Next-state logic and instruction capture; inputs outside their state are ignored
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_FETCH: if (arready) state_d = S_WAIT;
      S_WAIT: begin
        if (rvalid) begin
          inst_d      = rdata;
          fetch_err_d = (rresp != RESP_OKAY);
          state_d     = S_VALID;
        end
      end
      S_VALID: if (inst_ready) state_d = S_EXEC;
      S_EXEC:  if (npc_valid)  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM and captured-instruction registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_FETCH;
      inst_q      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // All outputs come from registered state only
  assign arvalid    = (state_q == S_FETCH);
  assign rready     = (state_q == S_WAIT);
  assign inst_valid = (state_q == S_VALID);
  assign araddr     = {pc[XLEN-1:2], 2'b00};
  assign inst       = inst_q;
  assign fetch_err  = fetch_err_q;
  assign opcode     = inst_q[6:0];
  assign funct3     = inst_q[14:12];
  assign funct7     = inst_q[31:25];
  assign funct12    = inst_q[31:20];

endmodule
